// File: rtl/execute_stage_pkg.sv
// Shared ALU select encodings, used by both ALU control and the execute stage.
package execute_stage_pkg;

  localparam int ALU_SEL_W = 4;

  localparam logic [ALU_SEL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_SEL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_SEL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_SEL_W-1:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX input bus and EX/MEM output bus of the execute stage.
// slave is the execute stage's view, master is the surrounding pipeline's.
interface execute_stage_if
  import execute_stage_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ALU_SEL_W-1:0]  alu_select;
  logic [WIDTH-1:0]      operand_a;
  logic [WIDTH-1:0]      operand_b;
  logic [WIDTH-1:0]      store_data_in;
  logic [REG_ADDR_W-1:0] rd_in;
  logic                  reg_write_in;
  logic                  mem_read_in;
  logic                  mem_write_in;
  logic                  branch_in;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      result;
  logic                  zero;
  logic                  overflow;
  logic                  branch_taken;
  logic                  illegal_op;
  logic [WIDTH-1:0]      store_data_out;
  logic [REG_ADDR_W-1:0] rd_out;
  logic                  reg_write_out;
  logic                  mem_read_out;
  logic                  mem_write_out;
  logic [CNT_W-1:0]      stall_count;

  modport slave (
    input  in_valid, alu_select, operand_a, operand_b, store_data_in, rd_in,
           reg_write_in, mem_read_in, mem_write_in, branch_in, flush, out_ready,
    output in_ready, out_valid, result, zero, overflow, branch_taken, illegal_op,
           store_data_out, rd_out, reg_write_out, mem_read_out, mem_write_out,
           stall_count
  );

  modport master (
    output in_valid, alu_select, operand_a, operand_b, store_data_in, rd_in,
           reg_write_in, mem_read_in, mem_write_in, branch_in, flush, out_ready,
    input  in_ready, out_valid, result, zero, overflow, branch_taken, illegal_op,
           store_data_out, rd_out, reg_write_out, mem_read_out, mem_write_out,
           stall_count
  );
endinterface

// File: rtl/execute_stage_alu_core.sv
// Combinational MIPS ALU: AND/OR/ADD/SUB/SLT with zero, signed overflow and
// an illegal flag for selects outside the supported set.
module execute_stage_alu_core
  import execute_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [ALU_SEL_W-1:0] select,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     result,
  output logic                 zero,
  output logic                 overflow,
  output logic                 illegal
);
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  // Operation select; undefined selects yield 0 and raise illegal.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (select)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: begin
        result   = sum;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: illegal = 1'b1;
    endcase
  end

  assign zero = (result == '0);
endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU plus EX/MEM pipeline register with valid/ready
// handshake, flush, and a saturating back-pressure stall counter.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input logic             clk,
  input logic             rst,
  execute_stage_if.slave  bus
);
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_overflow;
  logic             alu_illegal;
  logic             load;

  logic                  out_valid_reg;
  logic [WIDTH-1:0]      result_reg;
  logic                  zero_reg;
  logic                  overflow_reg;
  logic                  branch_taken_reg;
  logic                  illegal_op_reg;
  logic [WIDTH-1:0]      store_data_reg;
  logic [REG_ADDR_W-1:0] rd_reg;
  logic                  reg_write_reg;
  logic                  mem_read_reg;
  logic                  mem_write_reg;
  logic [CNT_W-1:0]      stall_count_reg;

  execute_stage_alu_core #(.WIDTH(WIDTH)) alu_core (
    .select   (bus.alu_select),
    .a        (bus.operand_a),
    .b        (bus.operand_b),
    .result   (alu_result),
    .zero     (alu_zero),
    .overflow (alu_overflow),
    .illegal  (alu_illegal)
  );

  // No skid buffer: accept only when the register is empty or draining.
  assign bus.in_ready = !out_valid_reg || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready;

  // Pipeline register and stall counter; priority rst > flush > load > drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg    <= 1'b0;
      result_reg       <= '0;
      zero_reg         <= 1'b0;
      overflow_reg     <= 1'b0;
      branch_taken_reg <= 1'b0;
      illegal_op_reg   <= 1'b0;
      store_data_reg   <= '0;
      rd_reg           <= '0;
      reg_write_reg    <= 1'b0;
      mem_read_reg     <= 1'b0;
      mem_write_reg    <= 1'b0;
      stall_count_reg  <= '0;
    end else begin
      if (out_valid_reg && !bus.out_ready && (stall_count_reg != '1)) begin
        stall_count_reg <= stall_count_reg + 1'b1;
      end
      if (bus.flush) begin
        out_valid_reg <= 1'b0;
      end else if (load) begin
        out_valid_reg    <= 1'b1;
        result_reg       <= alu_result;
        zero_reg         <= alu_zero;
        overflow_reg     <= alu_overflow;
        branch_taken_reg <= bus.branch_in && alu_zero && !alu_illegal;
        illegal_op_reg   <= alu_illegal;
        store_data_reg   <= bus.store_data_in;
        rd_reg           <= bus.rd_in;
        reg_write_reg    <= bus.reg_write_in && !alu_illegal;
        mem_read_reg     <= bus.mem_read_in && !alu_illegal;
        mem_write_reg    <= bus.mem_write_in && !alu_illegal;
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.out_valid      = out_valid_reg;
  assign bus.result         = result_reg;
  assign bus.zero           = zero_reg;
  assign bus.overflow       = overflow_reg;
  assign bus.branch_taken   = branch_taken_reg;
  assign bus.illegal_op     = illegal_op_reg;
  assign bus.store_data_out = store_data_reg;
  assign bus.rd_out         = rd_reg;
  assign bus.reg_write_out  = reg_write_reg;
  assign bus.mem_read_out   = mem_read_reg;
  assign bus.mem_write_out  = mem_write_reg;
  assign bus.stall_count    = stall_count_reg;
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus a random
// run compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_execute_stage;
  localparam int W    = 32;
  localparam int RW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic          valid;
    logic [W-1:0]  result;
    logic          zero;
    logic          ovf;
    logic          bt;
    logic          ill;
    logic [W-1:0]  sd;
    logic [RW-1:0] rd;
    logic          rw;
    logic          mr;
    logic          mw;
  } view_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  execute_stage_if #(.WIDTH(W), .REG_ADDR_W(RW), .CNT_W(CW)) bus ();

  execute_stage #(.WIDTH(W), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: the entry the stage should present after accepting these inputs.
  function automatic view_t model_entry(input logic [3:0] sel, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [W-1:0] sd,
                                        input logic [RW-1:0] rd, input logic rw,
                                        input logic mr, input logic mw, input logic br);
    view_t  e;
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e = '0;
    e.valid = 1'b1;
    case (sel)
      4'b0000: e.result = a & b;
      4'b0001: e.result = a | b;
      4'b0010: begin
        s = sa + sb;
        e.result = W'(s);
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        s = sa - sb;
        e.result = W'(s);
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: e.result = (sa < sb) ? 32'd1 : 32'd0;
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.result == 0);
    e.bt   = br && e.zero && !e.ill;
    e.sd   = sd;
    e.rd   = rd;
    e.rw   = rw && !e.ill;
    e.mr   = mr && !e.ill;
    e.mw   = mw && !e.ill;
    return e;
  endfunction

  function automatic view_t observe();
    view_t o;
    o.valid  = bus.out_valid;
    o.result = bus.result;
    o.zero   = bus.zero;
    o.ovf    = bus.overflow;
    o.bt     = bus.branch_taken;
    o.ill    = bus.illegal_op;
    o.sd     = bus.store_data_out;
    o.rd     = bus.rd_out;
    o.rw     = bus.reg_write_out;
    o.mr     = bus.mem_read_out;
    o.mw     = bus.mem_write_out;
    return o;
  endfunction

  task automatic put(input logic v, input logic [3:0] sel, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] sd, input logic [RW-1:0] rd,
                     input logic rw, input logic mr, input logic mw, input logic br);
    bus.in_valid      = v;
    bus.alu_select    = sel;
    bus.operand_a     = a;
    bus.operand_b     = b;
    bus.store_data_in = sd;
    bus.rd_in         = rd;
    bus.reg_write_in  = rw;
    bus.mem_read_in   = mr;
    bus.mem_write_in  = mw;
    bus.branch_in     = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    view_t o;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    put(1'b1, 4'b0010, 32'd3, 32'd4, 32'hABCD, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    #1;
    o = observe();
    checks++;
    if (o !== view_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", o);
    end
    checks++;
    if (bus.stall_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_stall: got %0d want 0", bus.stall_count);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    put(1'b0, 4'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_ops();
    logic [3:0]   sels [5] = '{4'b0010, 4'b0110, 4'b0111, 4'b0000, 4'b0001};
    logic [W-1:0] as   [5] = '{32'd7, 32'd5, 32'hFFFFFFFF, 32'h0000F0F0, 32'h0000F0F0};
    logic [W-1:0] bs   [5] = '{32'd5, 32'd5, 32'd1, 32'h0000FF00, 32'h0000FF00};
    logic [W-1:0] want [5] = '{32'd12, 32'd0, 32'd1, 32'h0000F000, 32'h0000FFF0};
    view_t e, o;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      put(1'b1, sels[i], as[i], bs[i], 32'h100 + i, 5'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0);
      e = model_entry(sels[i], as[i], bs[i], 32'h100 + i, 5'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      o = observe();
      checks++;
      if (o.result !== want[i] || o.valid !== 1'b1) begin
        errors++;
        $display("FAIL op%0d_result: got %h valid %b want %h valid 1", i, o.result, o.valid, want[i]);
      end
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL op%0d_entry: got %h want %h", i, o, e);
      end
      $display("op sel=%b a=%h b=%h -> result=%h zero=%b", sels[i], as[i], bs[i], o.result, o.zero);
    end
    put(1'b0, 4'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'h0000FFF0) begin
      errors++;
      $display("FAIL drain: got valid %b result %h want valid 0 result 0000fff0",
               bus.out_valid, bus.result);
    end
  endtask

  task automatic test_overflow();
    logic [3:0]   sels [3] = '{4'b0010, 4'b0110, 4'b0010};
    logic [W-1:0] as   [3] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [W-1:0] bs   [3] = '{32'd1, 32'd1, 32'd1};
    logic [W-1:0] wres [3] = '{32'h80000000, 32'h7FFFFFFF, 32'h00000000};
    logic         wovf [3] = '{1'b1, 1'b1, 1'b0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(1'b1, sels[i], as[i], bs[i], 32'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checks++;
      if (bus.result !== wres[i] || bus.overflow !== wovf[i]) begin
        errors++;
        $display("FAIL ovf%0d: got result %h ovf %b want result %h ovf %b",
                 i, bus.result, bus.overflow, wres[i], wovf[i]);
      end
      $display("ovf sel=%b a=%h b=%h -> result=%h ovf=%b", sels[i], as[i], bs[i],
               bus.result, bus.overflow);
    end
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b1;
    put(1'b1, 4'b0101, 32'h12345678, 32'h9ABCDEF0, 32'hCAFE, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    checks++;
    if (bus.illegal_op !== 1'b1 || bus.result !== 32'd0 || bus.zero !== 1'b1 ||
        bus.reg_write_out !== 1'b0 || bus.mem_read_out !== 1'b0 ||
        bus.mem_write_out !== 1'b0 || bus.branch_taken !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL illegal: got ill %b res %h zero %b rw %b mr %b mw %b bt %b valid %b want 1 0 1 0 0 0 0 1",
               bus.illegal_op, bus.result, bus.zero, bus.reg_write_out, bus.mem_read_out,
               bus.mem_write_out, bus.branch_taken, bus.out_valid);
    end
    $display("illegal sel=0101 -> ill=%b result=%h", bus.illegal_op, bus.result);
    put(1'b0, 4'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    view_t ea, eb, o;
    do_reset();
    bus.out_ready = 1'b0;
    put(1'b1, 4'b0010, 32'd100, 32'd23, 32'hAAAA, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    ea = model_entry(4'b0010, 32'd100, 32'd23, 32'hAAAA, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    put(1'b1, 4'b0001, 32'h0F, 32'hF0, 32'hBBBB, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    eb = model_entry(4'b0001, 32'h0F, 32'hF0, 32'hBBBB, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      o = observe();
      checks++;
      if (o !== ea || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d: got %h in_ready %b want %h in_ready 0", i, o, bus.in_ready, ea);
      end
    end
    checks++;
    if (bus.stall_count !== 4'd3) begin
      errors++;
      $display("FAIL stall_count: got %0d want 3", bus.stall_count);
    end
    bus.out_ready = 1'b1;
    tick();
    o = observe();
    checks++;
    if (o !== eb) begin
      errors++;
      $display("FAIL drain_load: got %h want %h", o, eb);
    end
    $display("back_to_back stall=%0d next result=%h", bus.stall_count, o.result);
    put(1'b0, 4'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b1;
    put(1'b1, 4'b0010, 32'd1, 32'd1, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    put(1'b1, 4'b0000, 32'hFFFF, 32'hFFFF, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid: got %b want 0", bus.out_valid);
    end
    put(1'b0, 4'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'd2 || bus.rd_out !== 5'd1) begin
      errors++;
      $display("FAIL flush_dropped: got valid %b result %h rd %0d want valid 0 result 2 rd 1",
               bus.out_valid, bus.result, bus.rd_out);
    end
    checks++;
    if (bus.stall_count !== 4'd3) begin
      errors++;
      $display("FAIL flush_stall_kept: got %0d want 3", bus.stall_count);
    end
    put(1'b1, 4'b0110, 32'd4, 32'd4, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (bus.branch_taken !== 1'b1 || bus.zero !== 1'b1 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL branch: got bt %b zero %b valid %b want 1 1 1",
               bus.branch_taken, bus.zero, bus.out_valid);
    end
    $display("flush/branch bt=%b", bus.branch_taken);
    put(1'b0, 4'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    bus.out_ready = 1'b0;
    put(1'b1, 4'b0000, 32'd1, 32'd1, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    put(1'b0, 4'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (bus.stall_count !== 4'(CMAX)) begin
      errors++;
      $display("FAIL saturate: got %0d want %0d", bus.stall_count, CMAX);
    end
    $display("saturate stall=%0d", bus.stall_count);
    do_reset();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.stall_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_stall: got valid %b stall %0d want 0 0",
               bus.out_valid, bus.stall_count);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_random();
    logic [3:0] legal [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};
    view_t cur, nxt, o;
    int    cnt;
    logic  v, ordy, fl, rw, mr, mw, br, exp_rdy;
    logic [3:0]    sel;
    logic [W-1:0]  a, b, sd;
    logic [RW-1:0] rd;
    do_reset();
    cur = '0;
    cnt = 0;
    for (int c = 0; c < 300; c++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      sel  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal[$urandom_range(0, 4)];
      a    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      sd   = $urandom;
      rd   = 5'($urandom);
      {rw, mr, mw, br} = 4'($urandom);
      put(v, sel, a, b, sd, rd, rw, mr, mw, br);
      bus.out_ready = ordy;
      bus.flush     = fl;
      #1;
      exp_rdy = !cur.valid || ordy;
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rnd%0d_in_ready: got %b want %b", c, bus.in_ready, exp_rdy);
      end
      if (cur.valid && !ordy && cnt < CMAX) cnt++;
      nxt = cur;
      if (fl) nxt.valid = 1'b0;
      else if (v && exp_rdy) nxt = model_entry(sel, a, b, sd, rd, rw, mr, mw, br);
      else if (ordy) nxt.valid = 1'b0;
      cur = nxt;
      tick();
      o = observe();
      checks++;
      if (o !== cur || bus.stall_count !== 4'(cnt)) begin
        errors++;
        $display("FAIL rnd%0d_state: got %h stall %0d want %h stall %0d",
                 c, o, bus.stall_count, cur, cnt);
      end
    end
    bus.flush = 1'b0;
    $display("test_random done, final stall=%0d", cnt);
  endtask

  initial begin
    test_reset();
    test_ops();
    test_overflow();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
# execute_stage

Registered execute stage of the MIPS datapath, directly downstream of ALU control: consumes the 4-bit ALU select plus ID/EX operands and control, computes the ALU result, and holds it in an EX/MEM pipeline register with a valid/ready handshake. Provides flush for branch recovery, flags undefined selects, and keeps a saturating back-pressure stall counter.

## Interface
- WIDTH, 32, datapath width
- REG_ADDR_W, 5, destination register index width
- CNT_W, 16, stall counter width

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  ID/EX entry valid
- in_ready  output  1  stage can accept an entry this cycle
- alu_select  input  4  from ALU control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT; any other value undefined
- operand_a, operand_b  input  WIDTH  ALU operands
- store_data_in  input  WIDTH  rt value for stores
- rd_in  input  REG_ADDR_W  destination register
- reg_write_in, mem_read_in, mem_write_in, branch_in  input  1 each  control bits
- flush  input  1  kill registered entry
- out_valid  output  1  EX/MEM entry valid
- out_ready  input  1  MEM stage accepts
- result  output  WIDTH  ALU result
- zero  output  1  result == 0
- overflow  output  1  signed overflow on ADD/SUB
- branch_taken  output  1  branch_in & zero
- illegal_op  output  1  entry had undefined select
- store_data_out, rd_out, reg_write_out, mem_read_out, mem_write_out  output  registered copies
- stall_count  output  CNT_W  saturating count of stalled cycles

## Operation
- Combinational ALU on alu_select: AND, OR, ADD (a+b mod 2^WIDTH), SUB (a−b mod 2^WIDTH), SLT (signed a<b → 1, else 0, zero-extended).
- overflow: ADD when sign(a)==sign(b) and sign(result)!=sign(a); SUB when sign(a)!=sign(b) and sign(result)!=sign(a); 0 for other ops.
- Undefined select: result 0, zero 1, overflow 0, illegal_op 1; reg_write_out, mem_read_out, mem_write_out, branch_taken forced 0. Entry still passes as valid.
- in_ready = !out_valid | out_ready (combinational, no skid buffer).
- Load: in_valid & in_ready → register all outputs, out_valid 1.
- Hold: out_valid & !out_ready → all outputs stable; stall_count +1, saturates at all-ones.
- Drain: out_ready & !(in_valid & in_ready) → out_valid 0; data fields retain values.
- flush: out_valid 0 next cycle; takes priority over a simultaneous load (incoming entry dropped). Does not clear stall_count.

## Timing
- Latency 1 cycle input→output; throughput 1/cycle with out_ready held high.
- Reset (sync, rst high at edge): out_valid 0, all data/control outputs 0, stall_count 0; in_ready therefore 1 during/after reset. Reset mid-stall drops the held entry.
- rst outranks flush outranks load outranks hold.
- Simultaneous drain and load: new entry replaces old in same edge, out_valid stays 1.
- Outputs (except in_ready) are pure register outputs.

## Structure
- Shared package: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT 4-bit select constants; same package ALU control uses.
- Sub-module alu_core: combinational ALU (select, a, b → result, zero, overflow, illegal). Register, handshake, and counter live in execute_stage.

## Test plan
- Reset: assert rst 2 cycles with in_valid 1 → out_valid 0, all outputs 0, stall_count 0, in_ready 1.
- Ops: ADD 7+5 →12; SUB 5−5 →0, zero 1; SLT 0xFFFFFFFF vs 1 →1; AND 0xF0F0&0xFF00 →0xF000; OR →0xFFF0; each out_valid one cycle after load.
- Overflow: ADD 0x7FFFFFFF+1 → 0x80000000, overflow 1; SUB 0x80000000−1 → overflow 1.
- Undefined select 0101 with reg_write_in 1 → illegal_op 1, result 0, reg_write_out 0.
- Back-pressure: load, hold out_ready 0 for 3 cycles → outputs stable, in_ready 0, stall_count 3; release → next entry loads same edge as drain.
- Flush with simultaneous in_valid → out_valid 0 next cycle, incoming entry not seen; branch_in 1 with SUB 4−4 otherwise → branch_taken 1.
